// File: rtl/jesd204_tx_gearbox_66_64.sv
// Per-lane 66b->64b transmit gearbox for JESD204C 64B/66B link mode.
// Packs {payload, sync header} blocks into a continuous 64-bit stream.
// 32 blocks are consumed in every 33 cycles; the 33rd cycle drains the residue.
module jesd204_tx_gearbox_66_64 #(
  parameter int unsigned NUM_LANES = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [64*NUM_LANES-1:0]   in_data,
  input  logic [2*NUM_LANES-1:0]    in_header,
  output logic                      in_ready,
  output logic [64*NUM_LANES-1:0]   out_data,
  output logic                      out_valid
);

  localparam int unsigned WORD_W  = 64;
  localparam int unsigned HDR_W   = 2;
  localparam int unsigned BLOCK_W = WORD_W + HDR_W;
  localparam int unsigned WIDE_W  = 2 * WORD_W;
  localparam int unsigned SEQ_W   = 6;
  localparam logic [SEQ_W-1:0] SEQ_DRAIN = SEQ_W'(32);

  logic [SEQ_W-1:0] seq_q;
  logic [SEQ_W-1:0] seq_next_c;
  logic [SEQ_W-1:0] shamt_c;
  logic             drain_c;

  // Sequence decode: drain slot, next count and even shift amount (2*seq).
  always_comb begin
    drain_c    = (seq_q == SEQ_DRAIN);
    seq_next_c = drain_c ? '0 : seq_q + SEQ_W'(1);
    shamt_c    = {seq_q[SEQ_W-2:0], 1'b0};
  end

  // Shared sequence counter, registered in_ready and sticky out_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      seq_q    <= seq_next_c;
      in_ready <= (seq_next_c != SEQ_DRAIN);
      if (!drain_c) begin
        out_valid <= 1'b1;
      end
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [BLOCK_W-1:0] block_c;
    logic [WIDE_W-1:0]  wide_c;
    logic [WORD_W-1:0]  residue_q;
    logic [WORD_W-1:0]  word_q;

    // Shift the block past the 2*seq residue bits; the upper half is the new residue.
    always_comb begin
      block_c = {in_data[l*WORD_W +: WORD_W], in_header[l*HDR_W +: HDR_W]};
      wide_c  = WIDE_W'(block_c) << shamt_c;
    end

    // Output word and residue update; drain slot flushes the full residue.
    always_ff @(posedge clk) begin
      if (reset) begin
        residue_q <= '0;
        word_q    <= '0;
      end else if (drain_c) begin
        word_q    <= residue_q;
        residue_q <= '0;
      end else begin
        word_q    <= wide_c[WORD_W-1:0] | residue_q;
        residue_q <= wide_c[WIDE_W-1:WORD_W];
      end
    end

    assign out_data[l*WORD_W +: WORD_W] = word_q;
  end

endmodule
